cabletest_seq: RTL and testbench

- Sequences one complete cable-test run across both packet-generator channels: latches run configuration, pulses generator start, waits for transmit to finish, then waits for the receive side to drain.
- Produces a single pass/fail verdict with cause bits.
- Sits between the AXI control-register block, which drives run/abort/config, and the two packet generator/checker pairs.

---
 rtl/cabletest_seq.sv | 192 +++++++++++++++++++
 tb/tb_cabletest_seq.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cabletest_seq.sv
// Cable-test run sequencer: drives both packet generators through one run and
// reports a sticky pass/fail verdict with cause bits.
module cabletest_seq #(
    parameter int unsigned START_WAIT = 64,
    parameter int unsigned DRAIN_WAIT = 1000000,
    parameter int unsigned TW         = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic        abort,
    input  logic [7:0]  cfg_cycles,
    input  logic [63:0] cfg_count,
    input  logic        busy1,
    input  logic        busy2,
    input  logic        sent1,
    input  logic        sent2,
    input  logic        rcvd1,
    input  logic        rcvd2,
    input  logic        err1,
    input  logic        err2,
    output logic        gen_start,
    output logic [7:0]  CYCLES_PER_PACKET,
    output logic [63:0] PACKET_COUNT,
    output logic        active,
    output logic        done,
    output logic [3:0]  status
);

    localparam int unsigned CW = 64;
    localparam int unsigned PW = 8;
    localparam int unsigned SW = 4;
    localparam logic [PW-1:0] CPP_RST = PW'(16);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state, state_d;
    logic [TW-1:0]  timer, timer_d, timer_inc;
    logic [CW-1:0]  rx1_cnt, rx1_cnt_d, rx1_inc;
    logic [CW-1:0]  rx2_cnt, rx2_cnt_d, rx2_inc;
    logic [CW-1:0]  tx1_cnt, tx1_cnt_d, tx1_inc;
    logic [CW-1:0]  tx2_cnt, tx2_cnt_d, tx2_inc;
    logic           gen_start_d, active_d, done_d;
    logic [SW-1:0]  status_d;
    logic [PW-1:0]  cpp_d;
    logic [CW-1:0]  pc_d;
    logic           in_run, rx_en, tx_en;

    // Saturating event counter step; never wraps past all-ones.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CW'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= S_IDLE;
            timer             <= '0;
            rx1_cnt           <= '0;
            rx2_cnt           <= '0;
            tx1_cnt           <= '0;
            tx2_cnt           <= '0;
            gen_start         <= 1'b0;
            active            <= 1'b0;
            done              <= 1'b0;
            status            <= '0;
            CYCLES_PER_PACKET <= CPP_RST;
            PACKET_COUNT      <= '0;
        end else begin
            state             <= state_d;
            timer             <= timer_d;
            rx1_cnt           <= rx1_cnt_d;
            rx2_cnt           <= rx2_cnt_d;
            tx1_cnt           <= tx1_cnt_d;
            tx2_cnt           <= tx2_cnt_d;
            gen_start         <= gen_start_d;
            active            <= active_d;
            done              <= done_d;
            status            <= status_d;
            CYCLES_PER_PACKET <= cpp_d;
            PACKET_COUNT      <= pc_d;
        end
    end

    // Next-state, counters and verdict; the incremented counts include this
    // cycle's pulses so a pulse coinciding with a transition is still counted.
    always_comb begin
        state_d     = state;
        timer_d     = timer;
        rx1_cnt_d   = rx1_cnt;
        rx2_cnt_d   = rx2_cnt;
        tx1_cnt_d   = tx1_cnt;
        tx2_cnt_d   = tx2_cnt;
        status_d    = status;
        cpp_d       = CYCLES_PER_PACKET;
        pc_d        = PACKET_COUNT;
        gen_start_d = 1'b0;
        active_d    = 1'b0;
        done_d      = 1'b0;

        in_run    = state inside {S_LAUNCH, S_WAIT_BUSY, S_RUN, S_DRAIN};
        rx_en     = state inside {S_RUN, S_DRAIN};
        tx_en     = state inside {S_LAUNCH, S_WAIT_BUSY, S_RUN};
        timer_inc = timer + TW'(1);
        rx1_inc   = sat_inc(rx1_cnt, rcvd1 && rx_en);
        rx2_inc   = sat_inc(rx2_cnt, rcvd2 && rx_en);
        tx1_inc   = sat_inc(tx1_cnt, sent1 && tx_en);
        tx2_inc   = sat_inc(tx2_cnt, sent2 && tx_en);

        if (in_run) begin
            rx1_cnt_d = rx1_inc;
            rx2_cnt_d = rx2_inc;
            tx1_cnt_d = tx1_inc;
            tx2_cnt_d = tx2_inc;
            if (err1 || (rx1_inc > PACKET_COUNT)) status_d[0] = 1'b1;
            if (err2 || (rx2_inc > PACKET_COUNT)) status_d[1] = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (run && (cfg_count != '0)) begin
                    state_d   = S_LAUNCH;
                    cpp_d     = cfg_cycles;
                    pc_d      = cfg_count;
                    rx1_cnt_d = '0;
                    rx2_cnt_d = '0;
                    tx1_cnt_d = '0;
                    tx2_cnt_d = '0;
                    timer_d   = '0;
                    status_d  = '0;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
                timer_d = '0;
            end
            S_WAIT_BUSY: begin
                if (busy1 || busy2) begin
                    state_d = S_RUN;
                end else if (timer_inc == TW'(START_WAIT)) begin
                    status_d[2] = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_RUN: begin
                // Transmit totals are audited only on a normal exit to DRAIN.
                if (!busy1 && !busy2) begin
                    state_d = S_DRAIN;
                    timer_d = '0;
                    if (tx1_inc != PACKET_COUNT) status_d[0] = 1'b1;
                    if (tx2_inc != PACKET_COUNT) status_d[1] = 1'b1;
                end
            end
            S_DRAIN: begin
                if ((rx1_inc == PACKET_COUNT) && (rx2_inc == PACKET_COUNT)) begin
                    state_d = S_DONE;
                end else if (timer_inc == TW'(DRAIN_WAIT)) begin
                    status_d[2] = 1'b1;
                    if (rx1_inc != PACKET_COUNT) status_d[0] = 1'b1;
                    if (rx2_inc != PACKET_COUNT) status_d[1] = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && in_run) begin
            status_d[3] = 1'b1;
            state_d     = S_DONE;
        end

        gen_start_d = (state_d == S_LAUNCH);
        done_d      = (state_d == S_DONE);
        active_d    = state_d inside {S_LAUNCH, S_WAIT_BUSY, S_RUN, S_DRAIN};
    end

endmodule

// File: tb/tb_cabletest_seq.sv
// Scenario bench for cabletest_seq: expected verdicts queued at run launch,
// popped and compared when done pulses.
module tb_cabletest_seq;

    localparam int unsigned DW = 100;
    localparam int unsigned SWAIT = 64;

    logic        clk = 1'b0;
    logic        resetn;
    logic        run, abort;
    logic [7:0]  cfg_cycles;
    logic [63:0] cfg_count;
    logic        busy1, busy2, sent1, sent2, rcvd1, rcvd2, err1, err2;
    logic        gen_start, active, done;
    logic [7:0]  CYCLES_PER_PACKET;
    logic [63:0] PACKET_COUNT;
    logic [3:0]  status;

    typedef struct packed {
        logic [3:0]  st;
        logic [63:0] pc;
        logic [7:0]  cpp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    cabletest_seq #(.START_WAIT(SWAIT), .DRAIN_WAIT(DW), .TW(32)) dut (
        .clk(clk), .resetn(resetn), .run(run), .abort(abort),
        .cfg_cycles(cfg_cycles), .cfg_count(cfg_count),
        .busy1(busy1), .busy2(busy2), .sent1(sent1), .sent2(sent2),
        .rcvd1(rcvd1), .rcvd2(rcvd2), .err1(err1), .err2(err2),
        .gen_start(gen_start), .CYCLES_PER_PACKET(CYCLES_PER_PACKET),
        .PACKET_COUNT(PACKET_COUNT), .active(active), .done(done), .status(status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input logic [63:0] cnt, input logic [7:0] cyc);
        cfg_count  = cnt;
        cfg_cycles = cyc;
        run        = 1'b1;
        tick(1);
        run        = 1'b0;
    endtask

    // Generator side: busy window carrying n sent pulses per channel.
    task automatic gen_burst(input int n, input logic e1);
        busy1 = 1'b1;
        busy2 = 1'b1;
        tick(1);
        for (int i = 0; i < n; i++) begin
            sent1 = 1'b1;
            sent2 = 1'b1;
            err1  = e1 && (i == 0);
            tick(1);
        end
        sent1 = 1'b0;
        sent2 = 1'b0;
        err1  = 1'b0;
        busy1 = 1'b0;
        busy2 = 1'b0;
        tick(1);
    endtask

    task automatic rx_drive(input int n1, input int n2);
        for (int i = 0; i < ((n1 > n2) ? n1 : n2); i++) begin
            rcvd1 = (i < n1);
            rcvd2 = (i < n2);
            tick(1);
        end
        rcvd1 = 1'b0;
        rcvd2 = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got, output int at);
        got = 1'b0;
        at  = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got = 1'b1;
                at  = cyc_no;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        run = 0; abort = 0; cfg_cycles = 0; cfg_count = 0;
        busy1 = 0; busy2 = 0; sent1 = 0; sent2 = 0;
        rcvd1 = 0; rcvd2 = 0; err1 = 0; err2 = 0;
        tick(3);
        checks++;
        if ({gen_start, active, done, status} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000", {gen_start, active, done, status});
        end
        checks++;
        if (CYCLES_PER_PACKET !== 8'd16 || PACKET_COUNT !== 64'd0) begin
            errors++;
            $display("FAIL reset_cfg: got cpp=%0d pc=%0d want cpp=16 pc=0", CYCLES_PER_PACKET, PACKET_COUNT);
        end
        resetn = 1'b1;
        tick(2);
        checks++;
        if (active !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got active=%b done=%b want 0 0", active, done);
        end
    endtask

    task automatic test_nominal();
        bit got; int at; exp_t e;
        sb.push_back('{st: 4'b0000, pc: 64'd4, cpp: 8'd16});
        start_run(4, 16);
        checks++;
        if (gen_start !== 1'b1 || active !== 1'b1) begin
            errors++;
            $display("FAIL nom_launch: got gen_start=%b active=%b want 1 1", gen_start, active);
        end
        tick(1);
        checks++;
        if (gen_start !== 1'b0 || active !== 1'b1) begin
            errors++;
            $display("FAIL nom_start_pulse: got gen_start=%b active=%b want 0 1", gen_start, active);
        end
        tick(1);
        gen_burst(4, 1'b0);
        rx_drive(4, 4);
        wait_done(20, got, at);
        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL nom_done: got no done want done");
        end else if (status !== e.st || PACKET_COUNT !== e.pc || CYCLES_PER_PACKET !== e.cpp || active !== 1'b0) begin
            errors++;
            $display("FAIL nom_verdict: got st=%b pc=%0d cpp=%0d act=%b want st=%b pc=%0d cpp=%0d act=0",
                     status, PACKET_COUNT, CYCLES_PER_PACKET, active, e.st, e.pc, e.cpp);
        end
        tick(1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL nom_done_pulse: got done=%b want 0", done);
        end
    endtask

    task automatic test_lost_packet();
        bit got; int at; int entry; exp_t e;
        sb.push_back('{st: 4'b0110, pc: 64'd3, cpp: 8'd16});
        start_run(3, 16);
        tick(2);
        gen_burst(3, 1'b0);
        entry = cyc_no;
        rx_drive(3, 2);
        wait_done(200, got, at);
        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL lost_done: got no done want done");
        end else if (status !== e.st || PACKET_COUNT !== e.pc) begin
            errors++;
            $display("FAIL lost_verdict: got st=%b pc=%0d want st=%b pc=%0d", status, PACKET_COUNT, e.st, e.pc);
        end
        checks++;
        if (got && (at - entry) != DW) begin
            errors++;
            $display("FAIL lost_latency: got %0d want %0d", at - entry, DW);
        end
        tick(1);
    endtask

    task automatic test_bit_error();
        bit got; int at; exp_t e;
        sb.push_back('{st: 4'b0001, pc: 64'd4, cpp: 8'd16});
        start_run(4, 16);
        tick(1);
        cfg_count  = 64'd9;
        cfg_cycles = 8'd5;
        run = 1'b1;
        tick(1);
        run = 1'b0;
        gen_burst(4, 1'b1);
        checks++;
        if (PACKET_COUNT !== 64'd4 || CYCLES_PER_PACKET !== 8'd16 || gen_start !== 1'b0) begin
            errors++;
            $display("FAIL midrun_run: got pc=%0d cpp=%0d gs=%b want pc=4 cpp=16 gs=0",
                     PACKET_COUNT, CYCLES_PER_PACKET, gen_start);
        end
        rx_drive(4, 4);
        wait_done(20, got, at);
        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL err_done: got no done want done");
        end else if (status !== e.st) begin
            errors++;
            $display("FAIL err_verdict: got st=%b want st=%b", status, e.st);
        end
        tick(1);
    endtask

    task automatic test_no_start();
        bit got; int at; int entry; exp_t e;
        sb.push_back('{st: 4'b0100, pc: 64'd2, cpp: 8'd16});
        start_run(2, 16);
        tick(1);
        entry = cyc_no;
        wait_done(200, got, at);
        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL nostart_done: got no done want done");
        end else if (status !== e.st || active !== 1'b0) begin
            errors++;
            $display("FAIL nostart_verdict: got st=%b act=%b want st=%b act=0", status, active, e.st);
        end
        checks++;
        if (got && (at - entry) != SWAIT) begin
            errors++;
            $display("FAIL nostart_latency: got %0d want %0d", at - entry, SWAIT);
        end
        tick(1);
    endtask

    task automatic test_overflow();
        bit got; int at; exp_t e;
        sb.push_back('{st: 4'b0101, pc: 64'd1, cpp: 8'd16});
        start_run(1, 16);
        tick(2);
        busy1 = 1'b1;
        busy2 = 1'b1;
        tick(1);
        sent1 = 1'b1; sent2 = 1'b1; rcvd1 = 1'b1;
        tick(1);
        sent1 = 1'b0; sent2 = 1'b0;
        tick(1);
        rcvd1 = 1'b0;
        checks++;
        if (status !== 4'b0001 || active !== 1'b1) begin
            errors++;
            $display("FAIL ovf_immediate: got st=%b act=%b want st=0001 act=1", status, active);
        end
        busy1 = 1'b0;
        busy2 = 1'b0;
        tick(1);
        rx_drive(0, 1);
        wait_done(200, got, at);
        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ovf_done: got no done want done");
        end else if (status !== e.st) begin
            errors++;
            $display("FAIL ovf_verdict: got st=%b want st=%b", status, e.st);
        end
        tick(1);
    endtask

    task automatic test_abort_and_ignores();
        exp_t e;
        sb.push_back('{st: 4'b1000, pc: 64'd5, cpp: 8'd8});
        start_run(5, 8);
        tick(2);
        busy1 = 1'b1;
        busy2 = 1'b1;
        tick(3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || active !== 1'b0 || status !== e.st || PACKET_COUNT !== e.pc) begin
            errors++;
            $display("FAIL abort_verdict: got done=%b act=%b st=%b pc=%0d want done=1 act=0 st=%b pc=%0d",
                     done, active, status, PACKET_COUNT, e.st, e.pc);
        end
        busy1 = 1'b0;
        busy2 = 1'b0;
        tick(1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_done_pulse: got done=%b want 0", done);
        end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        start_run(0, 3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (gen_start !== 1'b0 || done !== 1'b0 || active !== 1'b0) begin
                errors++;
                $display("FAIL zero_run_c%0d: got gs=%b done=%b act=%b want 0 0 0", i, gen_start, done, active);
            end
            tick(1);
        end
        checks++;
        if (status !== 4'b1000 || PACKET_COUNT !== 64'd5 || CYCLES_PER_PACKET !== 8'd8) begin
            errors++;
            $display("FAIL idle_hold: got st=%b pc=%0d cpp=%0d want st=1000 pc=5 cpp=8",
                     status, PACKET_COUNT, CYCLES_PER_PACKET);
        end
    endtask

    task automatic test_async_reset();
        start_run(4, 16);
        tick(2);
        gen_burst(4, 1'b1);
        rx_drive(2, 2);
        checks++;
        if (status !== 4'b0001 || active !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got st=%b act=%b want st=0001 act=1", status, active);
        end
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if ({gen_start, active, done, status} !== 7'b0 || PACKET_COUNT !== 64'd0 || CYCLES_PER_PACKET !== 8'd16) begin
            errors++;
            $display("FAIL async_reset: got ctl=%b pc=%0d cpp=%0d want ctl=0000000 pc=0 cpp=16",
                     {gen_start, active, done, status}, PACKET_COUNT, CYCLES_PER_PACKET);
        end
        tick(2);
        checks++;
        if (done !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL in_reset: got done=%b act=%b want 0 0", done, active);
        end
        resetn = 1'b1;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lost_packet();
        test_bit_error();
        test_no_start();
        test_overflow();
        test_abort_and_ignores();
        test_async_reset();
        test_nominal();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
